// File: rtl/exc_seq.sv
// rtl/exc_seq.sv - exception-entry / RTE control-register write sequencer
//
// Ports:
//   clock, reset          core clock, asynchronous active-low reset
//   hold                  pipeline hold; freezes state and all outputs
//   excReq/excCode/excTea trap request level, trap code, faulting address
//   rteReq                return-from-exception request level
//   cr*, gprSp            current control-register and SP values
//   crWr                  write strobes {SP,PC,TEA,SSP,SPC,EXSR,SR}
//   val*                  write data, held while the matching strobe is 0
//   pipeFlush, busy       high while sequencing (busy also in HALT)
//   excAck/rteAck/rteErr  single-cycle completion pulses
//   dblFault              sticky double-fault flag
module exc_seq #(
    parameter int VEC_SHIFT   = 3,
    parameter bit HALT_ON_DBL = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        hold,
    input  logic        excReq,
    input  logic [15:0] excCode,
    input  logic [63:0] excTea,
    input  logic        rteReq,
    input  logic [63:0] crSr,
    input  logic [63:0] crExsr,
    input  logic [63:0] crTea,
    input  logic [47:0] crPc,
    input  logic [47:0] crSpc,
    input  logic [47:0] crSsp,
    input  logic [47:0] crVbr,
    input  logic [47:0] gprSp,
    output logic [6:0]  crWr,
    output logic [63:0] valSr,
    output logic [63:0] valExsr,
    output logic [63:0] valTea,
    output logic [47:0] valSpc,
    output logic [47:0] valSsp,
    output logic [47:0] valPc,
    output logic [47:0] valSp,
    output logic        pipeFlush,
    output logic        busy,
    output logic        excAck,
    output logic        rteAck,
    output logic        rteErr,
    output logic        dblFault
);

    typedef enum logic [2:0] {
        IDLE, SAVE, SWAP, VECT, RSTR, DONE, HALT
    } state_t;

    localparam logic [6:0] WR_SAVE = 7'h16;  // EXSR, SPC, TEA
    localparam logic [6:0] WR_SWAP = 7'h49;  // SR, SSP, SP
    localparam logic [6:0] WR_VECT = 7'h20;  // PC
    localparam logic [6:0] WR_RSTR = 7'h69;  // SR, SSP, PC, SP

    state_t      state;
    logic [63:0] cap_sr;
    logic [47:0] cap_sp;
    logic [47:0] cap_ssp;
    logic [47:0] cap_vbr;
    logic [3:0]  cap_vec;

    // The current TEA and the low half of EXSR are overwritten, never read.
    logic unused_inputs;
    assign unused_inputs = ^{crTea, crExsr[31:0]};

    // Outputs are registered on the edge that enters a state, so each
    // state's strobes are visible during the cycle the FSM sits in it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cap_sr    <= '0;
            cap_sp    <= '0;
            cap_ssp   <= '0;
            cap_vbr   <= '0;
            cap_vec   <= '0;
            crWr      <= '0;
            valSr     <= '0;
            valExsr   <= '0;
            valTea    <= '0;
            valSpc    <= '0;
            valSsp    <= '0;
            valPc     <= '0;
            valSp     <= '0;
            pipeFlush <= 1'b0;
            busy      <= 1'b0;
            excAck    <= 1'b0;
            rteAck    <= 1'b0;
            rteErr    <= 1'b0;
            dblFault  <= 1'b0;
        end else if (!hold) begin
            case (state)
                IDLE: begin
                    if (excReq) begin
                        cap_sr    <= crSr;
                        cap_sp    <= gprSp;
                        cap_ssp   <= crSsp;
                        cap_vbr   <= crVbr;
                        cap_vec   <= excCode[15:12];
                        busy      <= 1'b1;
                        pipeFlush <= 1'b1;
                        if (crSr[28] && HALT_ON_DBL) begin
                            // Trap taken with BL already set.
                            state    <= HALT;
                            dblFault <= 1'b1;
                        end else begin
                            state   <= SAVE;
                            crWr    <= WR_SAVE;
                            valSpc  <= crPc;
                            valExsr <= {crSr[31:0], 16'h0000, excCode};
                            valTea  <= excTea;
                        end
                    end else if (rteReq) begin
                        busy      <= 1'b1;
                        pipeFlush <= 1'b1;
                        if (!crSr[30]) begin
                            // RTE from user mode is rejected without writes.
                            state  <= DONE;
                            rteAck <= 1'b1;
                            rteErr <= 1'b1;
                        end else begin
                            state  <= RSTR;
                            crWr   <= WR_RSTR;
                            valSr  <= {crSr[63:32], crExsr[63:32]};
                            valPc  <= crSpc;
                            valSp  <= crSsp;
                            valSsp <= gprSp;
                        end
                    end
                end
                SAVE: begin
                    state  <= SWAP;
                    crWr   <= WR_SWAP;
                    valSsp <= cap_sp;
                    valSp  <= cap_ssp;
                    valSr  <= cap_sr | 64'h0000_0000_7000_0000;
                end
                SWAP: begin
                    state <= VECT;
                    crWr  <= WR_VECT;
                    valPc <= cap_vbr + (48'(cap_vec) << VEC_SHIFT);
                end
                VECT: begin
                    state  <= DONE;
                    crWr   <= '0;
                    excAck <= 1'b1;
                end
                RSTR: begin
                    state  <= DONE;
                    crWr   <= '0;
                    rteAck <= 1'b1;
                end
                DONE: begin
                    state     <= IDLE;
                    excAck    <= 1'b0;
                    rteAck    <= 1'b0;
                    rteErr    <= 1'b0;
                    busy      <= 1'b0;
                    pipeFlush <= 1'b0;
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
